// File: rtl/window_acc8_pkg.sv
// window_acc8_pkg
// Shared definitions for the window accumulator: FSM state encoding,
// clamp limits and the default window length.
package window_acc8_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] SAT_MAX         = 8'hFF;
    localparam logic [7:0] SAT_MIN         = 8'h00;
    localparam int         WIN_LEN_DEFAULT = 9;

endpackage

// File: rtl/addu8.sv
// addu8
// 8-bit unsigned add/subtract with a single out-of-range indicator.
// Ports:
//   a, b  : operands (result is a + b or a - b)
//   cin   : 0 = add, 1 = subtract
//   sum   : low 8 bits of the result
//   cout  : add -> carry-out (overflow); subtract -> borrow (b > a)
module addu8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] wide;

    // A 9-bit unsigned difference has bit 8 set exactly when b > a, so the
    // same bit serves as carry on add and borrow on subtract.
    always_comb begin
        if (cin) begin
            wide = {1'b0, a} - {1'b0, b};
        end else begin
            wide = {1'b0, a} + {1'b0, b};
        end
    end

    assign sum  = wide[7:0];
    assign cout = wide[8];

endmodule

// File: rtl/window_acc8.sv
// window_acc8
// Accumulates WIN_LEN operand beats (add or subtract, clamped to 0..255)
// into an 8-bit result, then holds the result until the consumer takes it.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   ACCUM | accepting operand beats, in_ready=1, out_valid=0
//   HOLD  | window complete, result presented, out_valid=1, in_ready=0
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake
//   in_data, in_sub     : operand and operation (1 = subtract)
//   out_valid/out_ready : result handshake
//   out_data, out_sat   : clamped result, sticky saturation flag
module window_acc8
    import window_acc8_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_sub,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sat
);

    localparam logic [7:0] WIN_LEN_U8 = 8'(WIN_LEN);

    state_t     state, state_nxt;
    logic [7:0] acc, acc_nxt;
    logic [7:0] count, count_nxt;
    logic       sat, sat_nxt;
    logic [7:0] count_inc;
    logic [7:0] sum;
    logic       sum_cout;

    addu8 u_addu8 (
        .a    (acc),
        .b    (in_data),
        .cin  (in_sub),
        .sum  (sum),
        .cout (sum_cout)
    );

    assign count_inc = count + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            sat   <= sat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        sat_nxt   = sat;
        case (state)
            ACCUM: begin
                // in_ready is 1 throughout ACCUM, so in_valid alone means accept.
                if (in_valid) begin
                    count_nxt = count_inc;
                    if (sum_cout) begin
                        acc_nxt = in_sub ? SAT_MIN : SAT_MAX;
                        sat_nxt = 1'b1;
                    end else begin
                        acc_nxt = sum;
                    end
                    if (count_inc == WIN_LEN_U8) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACCUM;
                    acc_nxt   = '0;
                    count_nxt = '0;
                    sat_nxt   = 1'b0;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // All outputs come straight from registers.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign out_data  = acc;
    assign out_sat   = sat;

endmodule

// File: tb/tb_window_acc8.sv
// tb_window_acc8
// Drives window_acc8 (WIN_LEN=9 and WIN_LEN=1 instances) with directed and
// random windows and compares against a clamp-arithmetic reference model.
module tb_window_acc8;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, in_sub, out_valid, out_ready, out_sat;
    logic [7:0] in_data, out_data;
    logic       in_valid1, in_ready1, in_sub1, out_valid1, out_ready1, out_sat1;
    logic [7:0] in_data1, out_data1;

    int checks   = 0;
    int failures = 0;
    int m_acc;
    bit m_sat;
    int beat_d[$];
    bit beat_s[$];

    window_acc8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    window_acc8 #(.WIN_LEN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .in_sub    (in_sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .out_sat   (out_sat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic with clamping to 0..255.
    function automatic void model_beat(input int d, input bit s);
        if (s) begin
            if (d > m_acc) begin
                m_acc = 0;
                m_sat = 1'b1;
            end else begin
                m_acc = m_acc - d;
            end
        end else begin
            if (m_acc + d > 255) begin
                m_acc = 255;
                m_sat = 1'b1;
            end else begin
                m_acc = m_acc + d;
            end
        end
    endfunction

    task automatic load(input int n, input int d, input bit s);
        for (int i = 0; i < n; i++) begin
            beat_d.push_back(d);
            beat_s.push_back(s);
        end
    endtask

    // Sends the queued beats with random idle gaps and checks the result.
    task automatic run_window(input string tag, input int gap_max);
        m_acc = 0;
        m_sat = 1'b0;
        for (int i = 0; i < beat_d.size(); i++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                @(negedge clk);
                chk({tag, "_idle_valid"}, out_valid, 0);
            end
            chk({tag, "_in_ready"}, in_ready, 1);
            in_valid = 1'b1;
            in_data  = 8'(beat_d[i]);
            in_sub   = beat_s[i];
            model_beat(beat_d[i], beat_s[i]);
            @(posedge clk);
            @(negedge clk);
            if (i < beat_d.size() - 1) chk({tag, "_early_valid"}, out_valid, 0);
        end
        in_valid = 1'b0;
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_in_ready_hold"}, in_ready, 0);
        chk({tag, "_out_data"}, out_data, m_acc);
        chk({tag, "_out_sat"}, out_sat, m_sat);
        beat_d.delete();
        beat_s.delete();
    endtask

    task automatic drain(input string tag, input int hold_cycles);
        repeat (hold_cycles) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_data"}, out_data, m_acc);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, out_valid, 0);
        chk({tag, "_drain_ready"}, in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'd0; in_sub = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = 8'd0; in_sub1 = 1'b0; out_ready1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        rst = 1'b0;
        @(negedge clk);

        load(9, 10, 1'b0);
        run_window("add10", 0);
        chk("add10_value", out_data, 90);
        drain("add10", 0);

        load(1, 200, 1'b0); load(1, 100, 1'b0); load(7, 0, 1'b0);
        run_window("ovf", 0);
        chk("ovf_value", out_data, 255);
        chk("ovf_sat", out_sat, 1);
        drain("ovf", 0);

        load(1, 5, 1'b0); load(1, 9, 1'b1); load(1, 3, 1'b0); load(6, 0, 1'b0);
        run_window("udf", 0);
        chk("udf_value", out_data, 3);
        chk("udf_sat", out_sat, 1);
        drain("udf", 0);

        // Backpressure: offered beats in HOLD must not be consumed.
        load(9, 20, 1'b0);
        run_window("bp", 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(255, 1));
            in_sub   = 1'($urandom_range(1, 0));
            @(posedge clk);
            @(negedge clk);
            chk("bp_stall_valid", out_valid, 1);
            chk("bp_stall_ready", in_ready, 0);
            chk("bp_stall_data", out_data, 180);
            chk("bp_stall_sat", out_sat, 0);
        end
        in_valid = 1'b0;
        drain("bp", 0);
        load(9, 1, 1'b0);
        run_window("bp_next", 0);
        chk("bp_next_value", out_data, 9);
        drain("bp_next", 0);

        // Asynchronous reset mid-window.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'd50; in_sub = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_acc", out_data, 200);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_data", out_data, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sat", out_sat, 0);
        chk("arst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        load(9, 1, 1'b0);
        run_window("post_rst", 0);
        chk("post_rst_value", out_data, 9);
        chk("post_rst_sat", out_sat, 0);
        drain("post_rst", 0);

        load(9, 7, 1'b0);
        run_window("gaps", 3);
        chk("gaps_value", out_data, 63);
        drain("gaps", 2);

        for (int w = 0; w < 20; w++) begin
            for (int b = 0; b < 9; b++) begin
                beat_d.push_back(int'($urandom_range(255, 0)));
                beat_s.push_back(1'($urandom_range(1, 0)));
            end
            run_window("rand", 2);
            drain("rand", int'($urandom_range(3, 0)));
        end

        // WIN_LEN=1: every accepted beat produces a result.
        for (int k = 0; k < 10; k++) begin
            int d;
            bit s;
            d = int'($urandom_range(255, 0));
            s = 1'($urandom_range(1, 0));
            chk("w1_in_ready", in_ready1, 1);
            in_valid1 = 1'b1; in_data1 = 8'(d); in_sub1 = s;
            @(posedge clk);
            @(negedge clk);
            in_valid1 = 1'b0;
            chk("w1_out_valid", out_valid1, 1);
            chk("w1_out_data", out_data1, s ? 0 : d);
            chk("w1_out_sat", out_sat1, (s && d != 0) ? 1 : 0);
            out_ready1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready1 = 1'b0;
            chk("w1_drain_valid", out_valid1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_acc8.md
WINDOW_ACC8 -- requirements
Module: window_acc8

Interface
REQ-001 SHALL have parameter WIN_LEN, default 9, meaning operand beats per window; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand beat offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operand this cycle.
REQ-006 SHALL have port in_data  input  8  unsigned operand.
REQ-007 SHALL have port in_sub  input  1  1 = subtract in_data from accumulator; 0 = add.
REQ-008 SHALL have port out_valid  output  1  window result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port out_data  output  8  saturated unsigned window result.
REQ-011 SHALL have port out_sat  output  1  at least one clamp occurred in the window.

Function
REQ-012 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-013 SHALL treat a beat as accepted only when in_valid=1 and in_ready=1 on a rising edge.
REQ-014 SHALL, on each accepted beat, set acc <= acc + in_data (in_sub=0) or acc - in_data (in_sub=1), 8-bit unsigned.
REQ-015 SHALL clamp an add whose carry-out is 1 to 8'hFF, and set the sticky saturation flag.
REQ-016 SHALL clamp a subtract that borrows (in_data > acc) to 8'h00, and set the sticky saturation flag.
REQ-017 SHALL apply clamping per beat; later beats operate on the clamped value.
REQ-018 SHALL count accepted beats (8-bit counter) and, on the beat that makes the count equal WIN_LEN, transition to HOLD in the next cycle.
REQ-019 SHALL present out_data and out_sat, including the effect of the final beat, in the first HOLD cycle (latency 1 cycle after the last accepted beat).
REQ-020 SHALL hold out_data, out_sat and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, in HOLD with out_ready=1, return to ACCUM next cycle with acc=0, count=0, saturation flag=0.
REQ-022 SHALL ignore in_valid in HOLD; no beat is consumed and no state changes.
REQ-023 SHALL tolerate arbitrary in_valid gaps; idle cycles do not advance the counter.
REQ-024 SHALL, with WIN_LEN=1, produce a result after every single accepted beat.
REQ-025 SHALL drive out_data from the accumulator register and out_valid/in_ready from the state register only (no combinational input-to-output paths).

Reset
REQ-026 SHALL, on rst=1 at any time, including mid-window or in HOLD, immediately force state=ACCUM, acc=0, count=0, flag=0, out_valid=0, out_data=0, out_sat=0, in_ready=1.
REQ-027 SHALL discard any partially accumulated window on reset; the first window after rst deasserts starts from 0.

Structure
REQ-028 SHALL place the state enum (ACCUM, HOLD), SAT_MAX=8'hFF, SAT_MIN=8'h00 and the WIN_LEN default in package window_acc8_pkg.
REQ-029 SHALL instantiate exactly one sub-module, addu8, for the add/subtract datapath: cin=in_sub; its cout drives the clamp decision (overflow on add, borrow on subtract).
REQ-030 SHALL keep the counter, state register and clamp multiplexer in window_acc8 itself.

Verification
REQ-031 SHALL cover: nine adds of 10 back-to-back -> out_valid in the cycle after the 9th accept, out_data=90, out_sat=0.
REQ-032 SHALL cover: add 200, add 100, seven adds of 0 -> out_data=255, out_sat=1.
REQ-033 SHALL cover: add 5, sub 9, add 3, six adds of 0 -> out_data=3, out_sat=1.
REQ-034 SHALL cover: result with out_ready=0 for 5 cycles while in_valid=1 -> out_data stable, in_ready=0, no beats consumed; after out_ready=1 the next window of nine 1s yields 9.
REQ-035 SHALL cover: rst pulse after 4 accepted beats of 50 -> all outputs 0 asynchronously; the following nine adds of 1 yield out_data=9, out_sat=0.
REQ-036 SHALL cover: nine adds of 7 with random in_valid gaps of 0-3 cycles -> out_data=63, and the counter does not advance on idle cycles.
